// File: rtl/shifter_pipe.sv
// shifter_pipe: four-stage rotate/shift pipeline with valid/ready flow control.
// Stage k conditionally moves the data by 2^(k-1) positions, steered by one bit of the count.
module shifter_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] In,
  input  logic [3:0]  Cnt,
  input  logic [1:0]  Op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Out,
  output logic        busy
);

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SLL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  // One conditional stage step; amt is always a nonzero power of two here.
  function automatic logic [15:0] step(input logic [15:0] d,
                                       input logic [1:0]  op,
                                       input logic        en,
                                       input int unsigned amt);
    logic [15:0] r;
    r = d;
    if (en) begin
      unique case (op_e'(op))
        OP_ROL:  r = (d << amt) | (d >> (16 - amt));
        OP_SLL:  r = d << amt;
        OP_ROR:  r = (d >> amt) | (d << (16 - amt));
        OP_SRL:  r = d >> amt;
        default: r = d;
      endcase
    end
    return r;
  endfunction

  logic        v1, v2, v3, v4;
  logic [15:0] d1, d2, d3, d4;
  logic [1:0]  o1, o2, o3;
  logic [2:0]  c1;
  logic [1:0]  c2;
  logic        c3;
  logic        advance;

  assign advance   = !v4 || out_ready;
  assign in_ready  = advance;
  assign out_valid = v4;
  assign Out       = d4;
  assign busy      = v1 | v2 | v3 | v4;

  // Each stage keeps only the count bits still needed downstream; bubbles carry zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      v4 <= 1'b0;
      d1 <= 16'h0000;
      d2 <= 16'h0000;
      d3 <= 16'h0000;
      d4 <= 16'h0000;
      o1 <= 2'b00;
      o2 <= 2'b00;
      o3 <= 2'b00;
      c1 <= 3'b000;
      c2 <= 2'b00;
      c3 <= 1'b0;
    end else if (advance) begin
      v1 <= in_valid;
      d1 <= in_valid ? step(In, Op, Cnt[0], 1) : 16'h0000;
      o1 <= in_valid ? Op : 2'b00;
      c1 <= in_valid ? Cnt[3:1] : 3'b000;

      v2 <= v1;
      d2 <= step(d1, o1, c1[0], 2);
      o2 <= o1;
      c2 <= c1[2:1];

      v3 <= v2;
      d3 <= step(d2, o2, c2[0], 4);
      o3 <= o2;
      c3 <= c2[1];

      v4 <= v3;
      d4 <= step(d3, o3, c3, 8);
    end
  end

endmodule

// File: tb/tb_shifter_pipe.sv
// tb_shifter_pipe: directed vector table plus hand-written latency, backpressure,
// reset and randomized sequences for shifter_pipe.
module tb_shifter_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] din;
  logic [3:0]  cnt;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  logic [15:0] expQ[$];
  logic        prevStall = 1'b0;
  logic [15:0] prevOut = 16'h0000;

  typedef struct {
    logic [15:0] a;
    logic [3:0]  n;
    logic [1:0]  o;
    logic [15:0] want;
  } vec_t;

  vec_t vecs[18];

  shifter_pipe dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .In(din),
    .Cnt(cnt),
    .Op(op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Out(dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single-step reference of each operation.
  function automatic logic [15:0] refModel(input logic [15:0] a, input logic [3:0] n,
                                           input logic [1:0] o);
    int s;
    s = int'(n);
    case (o)
      2'b00:   refModel = (a << s) | (a >> (16 - s));
      2'b01:   refModel = a << s;
      2'b10:   refModel = (a >> s) | (a << (16 - s));
      default: refModel = a >> s;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Drives one cycle, scores whatever is consumed before the next edge, queues accepted work.
  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [3:0] n,
                               input logic [1:0] o, input logic ordy, input logic [15:0] want);
    @(negedge clk);
    in_valid  = v;
    din       = a;
    cnt       = n;
    op        = o;
    out_ready = ordy;
    #1;
    if (prevStall) checkOutput("stalled Out hold", dout, prevOut);
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) checkOutput("spurious out_valid", 16'(out_valid), 16'h0000);
      else checkOutput("result", dout, expQ.pop_front());
    end
    prevStall = out_valid && !out_ready;
    prevOut   = dout;
    if (in_valid && in_ready && !rst) expQ.push_back(want);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((expQ.size() != 0 || busy) && k < budget) begin
      applyStimulus(1'b0, 16'h0000, 4'h0, 2'b00, 1'b1, 16'h0000);
      k++;
    end
    checkOutput("drain leftovers", 16'(expQ.size()), 16'h0000);
    checkOutput("drain busy", 16'(busy), 16'h0000);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    din       = 16'hFFFF;
    cnt       = 4'd1;
    op        = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    expQ.delete();
    prevStall = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; din = 16'h0; cnt = 4'h0; op = 2'b00; out_ready = 1'b0;

    vecs[0]  = '{16'h8001, 4'd1,  2'b00, 16'h0003};
    vecs[1]  = '{16'hF0F0, 4'd4,  2'b01, 16'h0F00};
    vecs[2]  = '{16'hF0F0, 4'd4,  2'b11, 16'h0F0F};
    vecs[3]  = '{16'h1234, 4'd8,  2'b10, 16'h3412};
    vecs[4]  = '{16'hA5A5, 4'd0,  2'b00, 16'hA5A5};
    vecs[5]  = '{16'hA5A5, 4'd0,  2'b01, 16'hA5A5};
    vecs[6]  = '{16'hA5A5, 4'd0,  2'b10, 16'hA5A5};
    vecs[7]  = '{16'hA5A5, 4'd0,  2'b11, 16'hA5A5};
    vecs[8]  = '{16'hA5A5, 4'd15, 2'b01, 16'h8000};
    vecs[9]  = '{16'hA5A5, 4'd15, 2'b11, 16'h0001};
    vecs[10] = '{16'h8001, 4'd1,  2'b10, 16'hC000};
    vecs[11] = '{16'h1234, 4'd4,  2'b00, 16'h2341};
    vecs[12] = '{16'h1234, 4'd12, 2'b00, 16'h4123};
    vecs[13] = '{16'hFFFF, 4'd15, 2'b10, 16'hFFFF};
    vecs[14] = '{16'h0001, 4'd15, 2'b00, 16'h8000};
    vecs[15] = '{16'h8000, 4'd3,  2'b11, 16'h1000};
    vecs[16] = '{16'h1234, 4'd3,  2'b01, 16'h91A0};
    vecs[17] = '{16'hA5A5, 4'd7,  2'b10, 16'h4B4B};

    // Reset with in_valid held high: nothing may be captured.
    doReset();
    checkOutput("reset out_valid", 16'(out_valid), 16'h0000);
    checkOutput("reset Out", dout, 16'h0000);
    checkOutput("reset busy", 16'(busy), 16'h0000);
    checkOutput("reset in_ready", 16'(in_ready), 16'h0001);

    // Latency: accepted at edge t, visible after edge t+3.
    @(negedge clk);
    in_valid = 1'b1; din = 16'h8001; cnt = 4'd1; op = 2'b00; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("latency t+0 valid", 16'(out_valid), 16'h0000);
    checkOutput("latency t+0 busy", 16'(busy), 16'h0001);
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      checkOutput("latency early valid", 16'(out_valid), 16'h0000);
    end
    @(posedge clk); #1;
    checkOutput("latency t+3 valid", 16'(out_valid), 16'h0001);
    checkOutput("latency t+3 Out", dout, 16'h0003);
    @(posedge clk); #1;
    checkOutput("latency consumed", 16'(out_valid), 16'h0000);
    prevStall = 1'b0;

    // Table streamed back to back; all results must follow on consecutive cycles.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].n, vecs[i].o, 1'b1, vecs[i].want);
      checkOutput("stream in_ready", 16'(in_ready), 16'h0001);
    end
    repeat (4) applyStimulus(1'b0, 16'h0000, 4'h0, 2'b00, 1'b1, 16'h0000);
    checkOutput("stream drained on time", 16'(expQ.size()), 16'h0000);
    drain(20);

    // Backpressure: fill, stall six cycles with a pending offer, then release.
    applyStimulus(1'b1, 16'h1234, 4'd4, 2'b00, 1'b0, 16'h2341);
    applyStimulus(1'b1, 16'h1234, 4'd4, 2'b10, 1'b0, 16'h4123);
    applyStimulus(1'b1, 16'h00FF, 4'd8, 2'b01, 1'b0, 16'hFF00);
    applyStimulus(1'b1, 16'hFF00, 4'd8, 2'b11, 1'b0, 16'h00FF);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 16'hDEAD, 4'd3, 2'b01, 1'b0, 16'hF568);
      checkOutput("stall in_ready", 16'(in_ready), 16'h0000);
      checkOutput("stall Out", dout, 16'h2341);
      checkOutput("stall busy", 16'(busy), 16'h0001);
    end
    checkOutput("stall queue depth", 16'(expQ.size()), 16'h0004);
    drain(20);

    // Reset with three operations in flight; none may ever emerge.
    applyStimulus(1'b1, 16'h1111, 4'd1, 2'b00, 1'b1, 16'h2222);
    applyStimulus(1'b1, 16'h3333, 4'd2, 2'b01, 1'b1, 16'hCCCC);
    applyStimulus(1'b1, 16'h5555, 4'd1, 2'b11, 1'b1, 16'h2AAA);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid reset out_valid", 16'(out_valid), 16'h0000);
    checkOutput("mid reset busy", 16'(busy), 16'h0000);
    expQ.delete();
    prevStall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 16'h0000, 4'h0, 2'b00, 1'b1, 16'h0000);
      checkOutput("post reset quiet", 16'(out_valid), 16'h0000);
    end

    // Random traffic against the single-step model.
    for (int i = 0; i < 400; i++) begin
      logic        v, r;
      logic [15:0] a;
      logic [3:0]  n;
      logic [1:0]  o;
      v = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 7);
      a = 16'($urandom);
      n = 4'($urandom_range(0, 15));
      o = 2'($urandom_range(0, 3));
      applyStimulus(v, a, n, o, r, refModel(a, n, o));
    end
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 16 bits, shift count at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  upstream offers an operation this cycle.
REQ-005 in_ready  output  1  block accepts the offered operation this cycle.
REQ-006 In  input  16  operand.
REQ-007 Cnt  input  4  shift/rotate amount, 0..15.
REQ-008 Op  input  2  operation: 00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical.
REQ-009 out_valid  output  1  Out holds a completed result.
REQ-010 out_ready  input  1  downstream consumes the result this cycle.
REQ-011 Out  output  16  result.
REQ-012 busy  output  1  high when any pipeline stage holds a valid entry.

Function
REQ-013 The block SHALL be a 4-stage registered pipeline S1..S4; each stage k SHALL hold a valid bit, 16-bit data, Op, and the unused Cnt bits.
REQ-014 Stage k SHALL apply a shift of 2^(k-1) positions (1, 2, 4, 8) to its incoming data iff Cnt bit k-1 is 1, otherwise pass the data through unchanged.
REQ-015 Rotates SHALL wrap vacated bits from the opposite end; logical shifts SHALL fill vacated bits with 0.
REQ-016 Result SHALL equal the single-step operation: ROL by n = (In<<n)|(In>>(16-n)); SLL = In<<n; ROR = (In>>n)|(In<<(16-n)); SRL = In>>n; all truncated to 16 bits.
REQ-017 Cnt=0 SHALL return In unchanged for every Op.
REQ-018 advance = !out_valid || out_ready; the whole pipeline SHALL shift by one stage on every rising edge where advance=1, and hold all stage registers otherwise.
REQ-019 in_ready SHALL equal advance (combinational); a transfer occurs when in_valid && in_ready at a rising edge.
REQ-020 On advance with no transfer, S1 SHALL load a bubble (valid=0); bubbles SHALL propagate and SHALL NOT be collapsed.
REQ-021 Latency: with out_ready held high, a transfer at edge t SHALL produce out_valid=1 with the correct Out after edge t+3 (4th edge counting t).
REQ-022 Throughput SHALL be one operation per cycle when out_ready is continuously high.
REQ-023 out_valid and Out SHALL come directly from S4 registers; Out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous consume and accept (out_valid && out_ready && in_valid) SHALL complete both in the same edge.
REQ-025 Results SHALL emerge in acceptance order; no operation SHALL be dropped or duplicated.
REQ-026 Out value when out_valid=0 is don't-care for checking but SHALL be deterministic (registered).
REQ-027 busy SHALL be the OR of S1..S4 valid bits.

Reset
REQ-028 With rst=1 at a rising edge, all stage valid bits SHALL clear to 0 and all stage data/Op/Cnt registers SHALL clear to 0.
REQ-029 After reset: out_valid=0, Out=16'h0000, busy=0, in_ready=1.
REQ-030 Reset SHALL override advance and any in-flight transfer; operations in flight at reset SHALL be discarded and never appear at Out.
REQ-031 in_valid during the rst=1 cycle SHALL NOT be accepted.

Verification
REQ-032 In=16'h8001, Cnt=1, Op=00, out_ready=1 -> out_valid 4 cycles later, Out=16'h0003.
REQ-033 Back-to-back: (16'hF0F0,Cnt=4,Op=01), (16'hF0F0,Cnt=4,Op=11), (16'h1234,Cnt=8,Op=10) -> Out 16'h0F00, 16'h0F0F, 16'h3412 on consecutive cycles.
REQ-034 Backpressure: fill with 4 ops, out_ready=0 for 6 cycles -> in_ready=0, Out frozen at first result, busy=1; release -> 4 results in order, no loss.
REQ-035 Boundary counts: In=16'hA5A5 with Cnt=0 all Ops -> 16'hA5A5; Cnt=15 Op=01 -> 16'h8000; Cnt=15 Op=11 -> 16'h0001.
REQ-036 Reset mid-operation: 3 ops in flight, assert rst one cycle -> out_valid=0, busy=0 next cycle; none of the 3 results ever appear.
REQ-037 Random stimulus with random in_valid/out_ready against reference model of REQ-016 -> zero mismatches, order preserved.
